// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: rx FSM state encoding and parity-sense constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; a push and a pop on the same edge
// both take effect, even when full. rdata reads 0 while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       rxclk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    // A pop frees the head slot on the same edge, so a full FIFO may still accept a push.
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with receive FIFO and sticky error flags.
// Optional parity bit is compiled in with UART_RX_PARITY_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            rxclk,
    input  logic                            reset,
    input  logic                            rx_enable,
    input  logic                            rx_in,
    input  logic                            parity_odd,
    input  logic                            uld_rx_data,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_empty,
    output logic                            rx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic                            rx_frame_err,
    output logic                            rx_parity_err,
    output logic                            rx_over_run
);

    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] TICK_FULL = CW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_e            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 sync1, s;
    logic                 stop_hit;
    logic                 good, push, frame_set, over_set;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= rx_in;
            s     <= sync1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
        end
    end

    // Every sample edge reloads the tick counter with 1, so the next sample lands
    // exactly OVERSAMPLE edges later.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        bit_n    = bit_idx;
        sh_n     = shreg;
        stop_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_n = CW'(1);
                if (!s) state_n = START;
            end
            START: begin
                if (cnt == TICK_HALF) begin
                    cnt_n   = CW'(1);
                    bit_n   = '0;
                    state_n = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == TICK_FULL) begin
                    cnt_n = CW'(1);
                    sh_n  = {s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == TICK_FULL) begin
                    cnt_n     = CW'(1);
                    par_bad_n = (s != ((^shreg) ^ (parity_odd == PAR_ODD)));
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == TICK_FULL) begin
                    stop_hit = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!rx_enable) begin
            state_n  = IDLE;
            stop_hit = 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_set;
    assign good    = stop_hit && s && !par_bad;
    assign par_set = stop_hit && s && par_bad;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            par_bad       <= par_bad_n;
            rx_parity_err <= par_set | (rx_parity_err & ~clr_err);
        end
    end
`else
    assign good          = stop_hit && s;
    assign rx_parity_err = 1'b0;
`endif

    // uld_rx_data pops the head on the edge it is sampled high; ignored while empty.
    assign frame_set = stop_hit && !s;
    assign over_set  = good && rx_full && !uld_rx_data;
    assign push      = good && !over_set;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_frame_err <= 1'b0;
            rx_over_run  <= 1'b0;
        end else begin
            rx_frame_err <= frame_set | (rx_frame_err & ~clr_err);
            rx_over_run  <= over_set | (rx_over_run & ~clr_err);
        end
    end

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .rxclk(rxclk),
        .reset(reset),
        .push (push),
        .wdata(shreg),
        .pop  (uld_rx_data),
        .rdata(rx_data),
        .empty(rx_empty),
        .full (rx_full),
        .count(rx_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (16x, 8 data bits, 4-entry FIFO); parity cases run when
// UART_RX_PARITY_EN is defined. Pops are checked against an expected-word queue.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int DEP = 4;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F   = 2 + DB + P;
    localparam int LAT = 3 + OS / 2 + (F - 1) * OS;

    logic          rxclk;
    logic          reset;
    logic          rx_enable;
    logic          rx_in;
    logic          parity_odd;
    logic          uld_rx_data;
    logic          clr_err;
    logic [DB-1:0] rx_data;
    logic          rx_empty;
    logic          rx_full;
    logic [2:0]    rx_count;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_over_run;

    int checks = 0;
    int errors = 0;
    logic [DB-1:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    logic par_force = 1'b0;
    logic par_val   = 1'b0;
`endif

    uart_rx_fifo #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(DEP)
    ) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .rx_enable    (rx_enable),
        .rx_in        (rx_in),
        .parity_odd   (parity_odd),
        .uld_rx_data  (uld_rx_data),
        .clr_err      (clr_err),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_count     (rx_count),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_over_run  (rx_over_run)
    );

    // clock / reset
    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers (always entered and left on a falling clock edge)
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge rxclk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_force ? par_val : ((^d) ^ parity_odd));
`endif
        drive_bit(stop_b);
        rx_in = 1'b1;
    endtask

    task automatic pop_word();
        uld_rx_data = 1'b1;
        @(negedge rxclk);
        uld_rx_data = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge rxclk);
        clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rxclk);
    endtask

    // monitor: every effective pop is compared against the expected queue
    always @(negedge rxclk) begin
        #3;
        if (uld_rx_data && !rx_empty && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", rx_data);
            end else begin
                logic [DB-1:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", rx_data, e);
                end
            end
        end
    end

    logic [DB-1:0] words[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    initial begin
        int n;
        reset       = 1'b1;
        rx_enable   = 1'b1;
        rx_in       = 1'b1;
        parity_odd  = PAR_EVEN;
        uld_rx_data = 1'b0;
        clr_err     = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(3);
        check("reset_empty", 32'(rx_empty), 32'd1);
        check("reset_full", 32'(rx_full), 32'd0);
        check("reset_count", 32'(rx_count), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_flags", {29'd0, rx_frame_err, rx_parity_err, rx_over_run}, 32'd0);

        // two back-to-back frames, with latency of the first push
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        fork
            begin
                send_frame(8'hA5, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                n = 0;
                while (rx_empty && n < 400) begin
                    @(posedge rxclk);
                    #1;
                    n++;
                end
                check("first_push_latency", 32'(n), 32'(LAT));
            end
        join
        idle(4);
        check("b2b_count", 32'(rx_count), 32'd2);
        check("b2b_head", 32'(rx_data), 32'hA5);
        pop_word();
        check("b2b_head2", 32'(rx_data), 32'h3C);
        pop_word();
        check("b2b_empty", 32'(rx_empty), 32'd1);

        // glitch shorter than half a bit, then a pop while empty
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(40);
        pop_word();
        check("glitch_count", 32'(rx_count), 32'd0);
        check("glitch_empty", 32'(rx_empty), 32'd1);
        check("glitch_flags", {29'd0, rx_frame_err, rx_parity_err, rx_over_run}, 32'd0);
        check("glitch_idle", 32'(dut.state), 32'(IDLE));

        // low stop bit
        send_frame(8'h55, 1'b0);
        idle(40);
        check("frame_err_set", 32'(rx_frame_err), 32'd1);
        check("frame_err_count", 32'(rx_count), 32'd0);
        pulse_clr();
        check("frame_err_clr", 32'(rx_frame_err), 32'd0);

        // overrun: five words into four slots, no pops
        for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
        for (int i = 0; i < 5; i++) send_frame(words[i], 1'b1);
        idle(4);
        check("ovr_flag", 32'(rx_over_run), 32'd1);
        check("ovr_full", 32'(rx_full), 32'd1);
        check("ovr_count", 32'(rx_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_word();
        check("ovr_drained", 32'(rx_empty), 32'd1);
        pulse_clr();
        check("ovr_clr", 32'(rx_over_run), 32'd0);

        // same again, popping on the fifth stop-sample edge
        for (int i = 0; i < 5; i++) exp_q.push_back(words[i]);
        for (int i = 0; i < 4; i++) send_frame(words[i], 1'b1);
        fork
            send_frame(words[4], 1'b1);
            begin
                idle(LAT - 1);
                pop_word();
            end
        join
        idle(4);
        check("pushpop_no_ovr", 32'(rx_over_run), 32'd0);
        check("pushpop_full", 32'(rx_full), 32'd1);
        check("pushpop_count", 32'(rx_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_word();
        check("pushpop_drained", 32'(rx_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: even parity needs 1, odd parity needs 0
        par_force  = 1'b1;
        par_val    = 1'b0;
        parity_odd = PAR_EVEN;
        send_frame(8'h07, 1'b1);
        idle(4);
        check("par_even_err", 32'(rx_parity_err), 32'd1);
        check("par_even_count", 32'(rx_count), 32'd0);
        pulse_clr();
        parity_odd = PAR_ODD;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        idle(4);
        check("par_odd_ok", 32'(rx_parity_err), 32'd0);
        check("par_odd_count", 32'(rx_count), 32'd1);
        pop_word();
        par_force  = 1'b0;
        parity_odd = PAR_EVEN;
`endif

        // reset mid-frame with a word queued and a flag set
        send_frame(8'h55, 1'b0);
        send_frame(8'h11, 1'b1);
        idle(4);
        check("pre_reset_count", 32'(rx_count), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_empty", 32'(rx_empty), 32'd1);
        check("async_rst_count", 32'(rx_count), 32'd0);
        check("async_rst_data", 32'(rx_data), 32'd0);
        check("async_rst_flags", {29'd0, rx_frame_err, rx_parity_err, rx_over_run}, 32'd0);
        rx_in = 1'b1;
        @(negedge rxclk);
        reset = 1'b0;
        idle(4);
        check("post_rst_idle", 32'(dut.state), 32'(IDLE));
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(4);
        check("post_rst_count", 32'(rx_count), 32'd1);
        pop_word();
        check("post_rst_empty", 32'(rx_empty), 32'd1);

        idle(4);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
